// File: rtl/fetch_prefetch_queue_pkg.sv
// Shared definitions for the instruction prefetch queue: word width, FSM encodings and the
// {pc, inst} entry type buffered between fetch and decode.
package fetch_prefetch_queue_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StReq     = 2'd1;
    localparam logic [1:0] StDiscard = 2'd2;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_prefetch_queue_if.sv
// Memory fetch port, redirect input and decode-side handshake of the prefetch queue.
// "master" is the prefetch queue itself; "slave" is the surrounding memory/decode/execute logic.
interface fetch_prefetch_queue_if
    import fetch_prefetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_inst;
    logic [XLEN-1:0] out_pc;
    logic [CntW-1:0] count;

    modport master (
        output imem_req, imem_addr, out_valid, out_inst, out_pc, count,
        input  imem_ack, imem_rdata, redirect, redirect_pc, out_ready
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_inst, out_pc, count,
        output imem_ack, imem_rdata, redirect, redirect_pc, out_ready
    );

endinterface

// File: rtl/fetch_prefetch_queue_fifo.sv
// First-word-fall-through FIFO of {pc, inst} entries with synchronous flush.
// Callers guarantee no push when full and no pop when empty.
module fetch_prefetch_queue_fifo
    import fetch_prefetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  fetch_entry_t               wdata,
    output fetch_entry_t               rdata,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    fetch_entry_t    mem [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= count_q + CntW'(push) - CntW'(pop);
        end
    end

    assign rdata = mem[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch stage: issues sequential word fetches, buffers {pc, inst} pairs for decode
// and flushes/restarts on a branch redirect. One memory request is outstanding at a time.
module fetch_prefetch_queue
    import fetch_prefetch_queue_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic                    clk,
    input logic                    rst,
    fetch_prefetch_queue_if.master bus
);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] target;
    logic [CntW-1:0] count;
    logic            xfer, push, pop, room, room_after_push;
    fetch_entry_t    wdata, head;

    assign target = bus.redirect_pc & ~XLEN'(3);
    assign xfer   = req_q & bus.imem_ack;
    assign pop    = (count != '0) & bus.out_ready & ~bus.redirect;
    assign push   = (state_q == StReq) & xfer & ~bus.redirect;
    assign wdata  = '{pc: fetch_pc_q, inst: bus.imem_rdata};

    // A slot is reserved at issue: only request if the entry will fit after this edge.
    assign room            = 32'(count) < DEPTH + 32'(pop);
    assign room_after_push = 32'(count) + 32'd1 < DEPTH + 32'(pop);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        case (state_q)
            StIdle: begin
                if (bus.redirect) begin
                    fetch_pc_d = target;
                end else if (room) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                if (bus.redirect) begin
                    fetch_pc_d = target;
                    state_d    = xfer ? StReq : StDiscard;
                end else if (xfer) begin
                    fetch_pc_d = fetch_pc_q + XLEN'(4);
                    state_d    = room_after_push ? StReq : StIdle;
                end
            end
            StDiscard: begin
                if (bus.redirect) begin
                    fetch_pc_d = target;
                end
                if (xfer) begin
                    state_d = StReq;
                end
            end
            default: state_d = StIdle;
        endcase
        req_d  = (state_d != StIdle);
        // The abandoned request keeps its address on the bus until memory acknowledges it.
        addr_d = (state_d == StDiscard) ? addr_q : fetch_pc_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            req_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
        end
    end

    fetch_prefetch_queue_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (bus.redirect),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (head),
        .count (count)
    );

    assign bus.imem_req  = req_q;
    assign bus.imem_addr = addr_q;
    assign bus.out_valid = (count != '0);
    assign bus.out_inst  = head.inst;
    assign bus.out_pc    = head.pc;
    assign bus.count     = count;

endmodule
